fpu_unary_arbiter: RTL and testbench
====================================

Name: fpu_unary_arbiter

Overview:
- Round-robin arbiter that shares one fixed-latency unary FPU unit (floor) among NREQ requesters.
- Accepts at most one operand per cycle via valid/ready and drives the unit's op input from a register.
- Tracks each issued operation's requester in a tag pipeline matched to the unit latency, then returns the unit result to that requester.
- Sits between the core's FPU issue logic and the floor instance; the unit itself is instantiated outside.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 2, clock edges from a unit_op change to the matching unit_result being valid (>=1).
- WIDTH, 32, operand/result width (IEEE single).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_op  in  NREQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant / accept.
- unit_op  out  WIDTH  registered operand to the shared unit.
- unit_result  in  WIDTH  result from the shared unit.
- resp_valid  out  NREQ  one-hot; the result on resp_data belongs to requester i.
- resp_data  out  WIDTH  equals unit_result (combinational passthrough).
- busy  out  1  any operation in flight.

Behaviour:
- Grant:
  - req_ready is combinational from req_valid and the priority pointer ptr.
  - The winner is the first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
  - req_ready is zero when no req_valid is high.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Accept: a requester is accepted at the edge where req_valid[i] and req_ready[i] are both high. Requesters hold req_valid and req_op stable until accepted.
- On accept at edge k:
  - unit_op <= req_op[winner].
  - ptr <= (winner+1) mod NREQ, wrapping from NREQ-1 to 0.
  - Tag stage 0 <= {valid=1, id=winner}.
- No accept: unit_op holds its value, ptr holds, tag stage 0 valid <= 0.
- Tag pipeline: LATENCY stages, shifts every cycle with no stall.
- Response:
  - resp_valid[id] is high in the cycle after edge k+LATENCY-1, i.e. exactly LATENCY cycles after the accept cycle.
  - Throughput is one result per cycle. Back-to-back accepts give back-to-back responses in issue order.
- Responses are not backpressured; requesters must sink them in the cycle they appear.
- busy = OR of all tag-stage valid bits.
- Reset values (reset sampled high at an edge):
  - ptr=0, unit_op=0, all tag valids=0.
  - Hence resp_valid=0 and busy=0.
  - req_ready is 0 during reset cycles regardless of req_valid.
- Reset mid-operation: in-flight tags are cleared and their results are never reported.
- Boundaries:
  - All NREQ requesting continuously: each is granted once per NREQ cycles.
  - Single requester holding valid: granted every cycle.
  - ptr pointing at an idle requester: search wraps past it with no wasted cycle.

Optional Feature:
- FPU_ARB_STATS_EN defined:
  - Adds output stat_grants, NREQ*16 bits.
  - One 16-bit saturating accept counter per requester; it sticks at 0xFFFF.
  - Counters are cleared by reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fpu_arb_pkg holds:
  - FPU_WIDTH = 32.
  - Type arb_tag_t {logic valid; logic [2:0] id}.
  - STAT_W = 16.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs one-hot grant and winner index. It is reused by later FPU sharing blocks.

Test Plan:
- Bench instantiates floor behind the arbiter with LATENCY=2; reset held high for 2 cycles.
- Single request: req0 with 0x3FC00000 (1.5) -> req_ready[0] same cycle; resp_valid=0001 with resp_data=0x3F800000 exactly 2 cycles later; busy high in between.
- Contention, all four requesting from reset:
  - Operands: req0 0xBFC00000 (-1.5), req1 0x40490FDB (pi), req2 0x00000000, req3 0x7F000000.
  - Grants in order 0,1,2,3.
  - Responses in consecutive cycles: 0xC0000000, 0x40400000, 0x00000000, 0x7F000000.
- Wrap fairness: requesters 3 and 0 held valid for 8 cycles after req3 was last granted -> grants alternate 0,3,0,3; each accepted 4 times.
- Reset mid-flight: accept req2 with 0x41200000, assert reset at the next edge -> no resp_valid ever for it; ptr back to 0; busy=0.
- Stats (FPU_ARB_STATS_EN): req1 alone held for 70000 cycles -> stat_grants[1]=0xFFFF, others 0; reset clears all counters to 0.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// -----------------------------------------------------------------------------
// fpu_arb_pkg
// Shared definitions for the FPU sharing blocks: the operand width, the
// requester-id width, the tag record that follows each issued operation down
// the latency pipeline, and the width of the optional grant counters.
// -----------------------------------------------------------------------------
package fpu_arb_pkg;

   localparam int FPU_WIDTH = 32;   // IEEE single
   localparam int STAT_W    = 16;   // per-requester accept counter width
   localparam int ID_W      = 3;    // enough for up to 8 requesters

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } arb_tag_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick. Searches req_i starting at ptr_i and wrapping
// modulo NREQ; the first set bit wins.
//
// Ports:
//   req_i     in   NREQ  request vector
//   ptr_i     in   ID_W  index searched first (must be < NREQ)
//   grant_o   out  NREQ  one-hot grant, zero when req_i is zero
//   winner_o  out  ID_W  index of the granted bit (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_pick
   import fpu_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] winner_o
);

   logic found;

   // Index visited at search step k.
   function automatic int search_idx(input logic [ID_W-1:0] p, input int k);
      return (int'(p) + k) % NREQ;
   endfunction

   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; a path that leaves one unassigned infers a latch.
      grant_o  = '0;
      winner_o = '0;
      found    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && (i == search_idx(ptr_i, k)) && req_i[i]) begin
               grant_o[i] = 1'b1;
               winner_o   = ID_W'(i);
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fpu_unary_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_unary_arbiter
// Shares one fixed-latency unary FPU unit (e.g. floor) among NREQ requesters.
// One operand is accepted per cycle by round-robin; the operand is registered
// onto unit_op and the requester id travels down a LATENCY-deep tag pipeline so
// that the unit result can be steered back to its owner.
//
// Ports:
//   clk          in   1           clock, rising edge
//   reset        in   1           synchronous active-high reset
//   req_valid    in   NREQ        request valid per requester
//   req_op       in   NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    out  NREQ        one-hot grant/accept (combinational)
//   unit_op      out  WIDTH       registered operand to the shared unit
//   unit_result  in   WIDTH       result from the shared unit
//   resp_valid   out  NREQ        one-hot owner of resp_data this cycle
//   resp_data    out  WIDTH       unit_result passthrough
//   busy         out  1           any operation in flight
//   stat_grants  out  NREQ*16     saturating accept counters (FPU_ARB_STATS_EN)
//
// Build option: define FPU_ARB_STATS_EN to add the stat_grants counters.
// -----------------------------------------------------------------------------
module fpu_unary_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int LATENCY = 2,
   parameter int WIDTH   = FPU_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_op,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        unit_op,
   input  logic [WIDTH-1:0]        unit_result,
   output logic [NREQ-1:0]         resp_valid,
   output logic [WIDTH-1:0]        resp_data,
   output logic                    busy
`ifdef FPU_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0]  stat_grants
`endif
);

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] unit_op_q, unit_op_d;
   arb_tag_t         tag_q [LATENCY];
   arb_tag_t         tag0_d;

   logic [NREQ-1:0]  grant;
   logic [ID_W-1:0]  winner;
   logic             accept;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i    (req_valid),
      .ptr_i    (ptr_q),
      .grant_o  (grant),
      .winner_o (winner)
   );

   always_comb begin
      // Nothing is granted while reset is asserted, so no accept can race it.
      req_ready = reset ? '0 : grant;
      accept    = |req_ready;
      ptr_d     = ptr_q;
      unit_op_d = unit_op_q;
      tag0_d    = '{valid: accept, id: winner};
      if (accept) begin
         ptr_d = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) unit_op_d = req_op[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= '0;
         unit_op_q <= '0;
         // NOTE: only the tag valid bits are reset; an id behind valid=0 is never
         // looked at, so clearing it would be wasted reset fan-out.
         for (int s = 0; s < LATENCY; s++) tag_q[s].valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every pipeline stage capture its
         // neighbour's pre-edge value regardless of statement order.
         ptr_q     <= ptr_d;
         unit_op_q <= unit_op_d;
         tag_q[0]  <= tag0_d;
         for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   // The last tag stage lines up with the unit result of the same operation.
   always_comb begin
      resp_valid = '0;
      busy       = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         resp_valid[i] = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == ID_W'(i));
      end
      for (int s = 0; s < LATENCY; s++) busy = busy | tag_q[s].valid;
   end

   assign unit_op   = unit_op_q;
   assign resp_data = unit_result;

`ifdef FPU_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NREQ];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            // Saturate: stop counting once all ones.
            if (req_ready[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_stat
      assign stat_grants[g*STAT_W +: STAT_W] = stat_q[g];
   end
`endif

endmodule

// File: tb/tb_fpu_unary_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_unary_arbiter
// Drives the arbiter with a floor unit (one register stage, LATENCY=2) hung off
// unit_op/unit_result. Directed table rows and hand sequences use constants;
// every cycle is also compared against a queue-based reference model.
// Define FPU_ARB_STATS_EN to include the counter sequence.
// -----------------------------------------------------------------------------
module tb_fpu_unary_arbiter;
   import fpu_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int LATENCY = 2;
   localparam int W       = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*W-1:0]   req_op;
   logic [NREQ-1:0]     req_ready;
   logic [W-1:0]        unit_op;
   logic [W-1:0]        unit_result;
   logic [NREQ-1:0]     resp_valid;
   logic [W-1:0]        resp_data;
   logic                busy;
`ifdef FPU_ARB_STATS_EN
   logic [NREQ*STAT_W-1:0] stat_grants;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fpu_unary_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .req_ready   (req_ready),
      .unit_op     (unit_op),
      .unit_result (unit_result),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .busy        (busy)
`ifdef FPU_ARB_STATS_EN
      ,
      .stat_grants (stat_grants)
`endif
   );

   always #5 clk = ~clk;

   // IEEE single floor, computed on the bit fields.
   function automatic logic [31:0] fp_floor(input logic [31:0] x);
      int          e;
      int          fb;
      logic [31:0] mask;
      e = int'(x[30:23]);
      if (e >= 150) return x;                       // integer, inf or NaN
      if (e < 127) begin                            // |x| < 1
         if (x[30:0] == 31'd0) return x;
         return x[31] ? 32'hBF80_0000 : 32'h0000_0000;
      end
      fb   = 150 - e;
      mask = (32'h1 << fb) - 32'h1;
      if ((x & mask) == 32'h0) return x;
      return x[31] ? ((x & ~mask) + (32'h1 << fb)) : (x & ~mask);
   endfunction

   // Shared unit: one register stage, so result is ready LATENCY cycles after accept.
   logic [W-1:0] unit_q;
   always @(posedge clk) unit_q <= fp_floor(unit_op);
   assign unit_result = unit_q;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (cycle time %0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      int          id;
      logic [31:0] data;
   } pend_t;

   pend_t        pend[$];
   int           m_ptr = 0;
   logic [31:0]  m_unit_op = '0;
   bit           m_init = 1'b0;
   int           cyc = 0;

   // Outputs sampled mid-cycle by the last cycle() call.
   logic [NREQ-1:0] s_ready, s_rv;
   logic [W-1:0]    s_rd;
   logic            s_busy;

   // Entered #1 after a rising edge with inputs applied; returns #1 after the next.
   task automatic cycle();
      logic [NREQ-1:0] exp_ready, exp_rv;
      int              w;
      #4;
      exp_ready = '0;
      w = -1;
      if (!reset) begin
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (m_init) begin
         exp_rv = '0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv[pend[0].id] = 1'b1;
            check("resp_data", resp_data, pend[0].data);
         end
         check("resp_valid", 32'(resp_valid), 32'(exp_rv));
         check("busy", 32'(busy), 32'(pend.size() != 0));
         check("unit_op", unit_op, m_unit_op);
      end
      s_ready = req_ready;
      s_rv    = resp_valid;
      s_rd    = resp_data;
      s_busy  = busy;
      @(posedge clk);
      if (reset) begin
         m_ptr     = 0;
         m_unit_op = '0;
         pend.delete();
         m_init    = 1'b1;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
         if (w >= 0) begin
            m_ptr     = (w + 1) % NREQ;
            m_unit_op = req_op[w*W +: W];
            pend.push_back('{cyc + LATENCY, w, fp_floor(m_unit_op)});
         end
      end
      cyc++;
      #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic            rst;
      logic [NREQ-1:0] valid;
      logic [127:0]    ops;
      logic [NREQ-1:0] ready;
      logic [NREQ-1:0] rv;
      logic [31:0]     rd;
      logic            bsy;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [127:0] ops,
                               input logic [3:0] rdy, input logic [3:0] rv,
                               input logic [31:0] rd, input logic bsy);
      vec_t t;
      t.rst = rst; t.valid = v; t.ops = ops; t.ready = rdy; t.rv = rv; t.rd = rd; t.bsy = bsy;
      return t;
   endfunction

   localparam logic [127:0] OPS_S = {32'h0, 32'h0, 32'h0, 32'h3FC0_0000};
   localparam logic [127:0] OPS_C = {32'h7F00_0000, 32'h0000_0000, 32'h4049_0FDB, 32'hBFC0_0000};

   vec_t vecs[$];

   initial begin
      logic [31:0] op;
      int          seen;
      int          n0, n3;

      reset     = 1'b1;
      req_valid = '0;
      req_op    = '0;
      @(posedge clk);
      #1;

      // reset, single request, reset again with everyone asking, contention
      vecs.push_back(mk(1, 4'b0000, OPS_S, 4'b0000, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(1, 4'b0000, OPS_S, 4'b0000, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(0, 4'b0001, OPS_S, 4'b0001, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(0, 4'b0000, OPS_S, 4'b0000, 4'b0000, 32'h0, 1));
      vecs.push_back(mk(0, 4'b0000, OPS_S, 4'b0000, 4'b0001, 32'h3F80_0000, 1));
      vecs.push_back(mk(0, 4'b0000, OPS_S, 4'b0000, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(1, 4'b1111, OPS_C, 4'b0000, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(1, 4'b1111, OPS_C, 4'b0000, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(0, 4'b1111, OPS_C, 4'b0001, 4'b0000, 32'h0, 0));
      vecs.push_back(mk(0, 4'b1110, OPS_C, 4'b0010, 4'b0000, 32'h0, 1));
      vecs.push_back(mk(0, 4'b1100, OPS_C, 4'b0100, 4'b0001, 32'hC000_0000, 1));
      vecs.push_back(mk(0, 4'b1000, OPS_C, 4'b1000, 4'b0010, 32'h4040_0000, 1));
      vecs.push_back(mk(0, 4'b0000, OPS_C, 4'b0000, 4'b0100, 32'h0000_0000, 1));
      vecs.push_back(mk(0, 4'b0000, OPS_C, 4'b0000, 4'b1000, 32'h7F00_0000, 1));
      vecs.push_back(mk(0, 4'b0000, OPS_C, 4'b0000, 4'b0000, 32'h0, 0));

      foreach (vecs[n]) begin
         reset     = vecs[n].rst;
         req_valid = vecs[n].valid;
         req_op    = vecs[n].ops;
         cycle();
         check($sformatf("tbl%0d_ready", n), 32'(s_ready), 32'(vecs[n].ready));
         if (!vecs[n].rst) begin
            check($sformatf("tbl%0d_rv", n), 32'(s_rv), 32'(vecs[n].rv));
            check($sformatf("tbl%0d_busy", n), 32'(s_busy), 32'(vecs[n].bsy));
            if (vecs[n].rv != '0) check($sformatf("tbl%0d_rd", n), s_rd, vecs[n].rd);
         end
      end

      // Wrap fairness: req3 was granted last, so 0 and 3 alternate starting at 0.
      req_op    = OPS_C;
      req_valid = 4'b1001;
      n0 = 0;
      n3 = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         check($sformatf("fair_grant%0d", k), 32'(s_ready), (k % 2 == 0) ? 32'h1 : 32'h8);
         if (s_ready[0]) n0++;
         if (s_ready[3]) n3++;
      end
      check("fair_cnt0", n0, 4);
      check("fair_cnt3", n3, 4);
      req_valid = '0;
      repeat (3) cycle();

      // Reset mid-flight: accepted op must never be reported.
      req_op    = {32'h0, 32'h4120_0000, 32'h0, 32'h0};
      req_valid = 4'b0100;
      cycle();
      check("mid_accept", 32'(s_ready), 32'h4);
      req_valid = '0;
      reset     = 1'b1;
      cycle();
      reset = 1'b0;
      seen  = 0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (s_rv != '0) seen++;
         if (k == 0) check("mid_busy", 32'(s_busy), 32'h0);
      end
      check("mid_no_resp", seen, 0);
      req_op    = OPS_C;
      req_valid = 4'b1111;
      cycle();
      check("mid_ptr0", 32'(s_ready), 32'h1);
      req_valid = '0;
      repeat (3) cycle();

      // Random traffic with occasional resets; requesters hold until accepted.
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!(req_valid[i] && !s_ready[i])) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               op           = $urandom;
               op[30:23]    = 8'($urandom_range(118, 160));
               req_op[i*W +: W] = op;
            end
         end
         cycle();
      end
      reset     = 1'b0;
      req_valid = '0;
      repeat (4) cycle();

`ifdef FPU_ARB_STATS_EN
      reset = 1'b1;
      cycle();
      reset     = 1'b0;
      req_valid = 4'b0010;
      repeat (70000) cycle();
      req_valid = '0;
      cycle();
      for (int i = 0; i < NREQ; i++) begin
         check($sformatf("stat_sat%0d", i), 32'(stat_grants[i*STAT_W +: STAT_W]),
               (i == 1) ? 32'hFFFF : 32'h0);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycle();
      for (int i = 0; i < NREQ; i++) begin
         check($sformatf("stat_clr%0d", i), 32'(stat_grants[i*STAT_W +: STAT_W]), 32'h0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
